ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the MIPS single-cycle core: owns the program counter, requests instruction words from instruction memory over a valid/ready handshake, and presents the fetched word (Op = Instr[31:26], Func = Instr[5:0]) to the control decoder. It consumes the decoder's PCSrc selection plus the datapath's Zero flag, immediate and rs value to compute the next PC. PC advances only when the current instruction retires.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  byte address of requested word
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- stall  in  1  downstream hold; instruction does not retire
- PCSrc  in  2  next-PC select, ENCODE.v codes: NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JR
- Zero  in  1  ALU zero flag, qualifies NPC_BRANCH
- Imm32  in  32  sign-extended branch offset (word units)
- RegRs  in  32  rs value for NPC_JR
- Instr  out  32  held instruction word
- instr_valid  out  1  Instr/PC valid for decode/execute
- PC  out  32  address of Instr
- PC_plus4  out  32  PC + 4 (for jal/link paths)
- fetch_err  out  1  misaligned target trapped (see Configuration)

## Operation
- States: REQ, WAIT, HOLD, ERR (ERR exists only with IFU_ALIGN_CHECK_EN).
- REQ: imem_req=1, imem_addr=PC. imem_ready=1 → WAIT; else remain.
- WAIT: imem_req=0. imem_rvalid=1 → Instr<=imem_rdata, → HOLD. imem_rvalid outside WAIT ignored.
- HOLD: instr_valid=1. stall=0 → retire: PC<=NPC, → REQ (or ERR). stall=1 → hold all outputs unchanged.
- NPC, computed combinationally from registered PC and current inputs, all arithmetic mod 2^32:
  - NPC_PLUS4: PC+4
  - NPC_BRANCH: Zero ? PC+4+(Imm32<<2) : PC+4
  - NPC_JUMP: {PC_plus4[31:28], Instr[25:0], 2'b00}
  - NPC_JR: RegRs
- PCSrc/Zero/Imm32/RegRs are sampled only on the retire edge; ignored in other states.
- Reset (any state, including mid-WAIT): PC<=RESET_PC, Instr<=0, state<=REQ, fetch_err<=0. Instruction memory shares rst; a response outstanding at reset is discarded by memory, not by this block.

## Timing
- Reset values: imem_req=0 during the rst cycle, then 1 in first REQ cycle; imem_addr=RESET_PC; Instr=0; instr_valid=0; PC=RESET_PC; PC_plus4=RESET_PC+4; fetch_err=0.
- Outputs imem_req, instr_valid, fetch_err decoded from registered state; Instr, PC registered; PC_plus4 combinational from PC.
- Minimum retire interval 3 cycles (REQ with imem_ready=1, WAIT with imem_rvalid=1, HOLD with stall=0).
- imem_addr stable while imem_req=1 and imem_ready=0.
- PC wraps 32'hFFFF_FFFC+4 → 0 without flag.

## Configuration
- IFU_ALIGN_CHECK_EN defined: on retire, NPC[1:0]≠0 → PC<=NPC, state<=ERR, fetch_err=1, imem_req=0, instr_valid=0 until rst.
- Undefined: NPC[1:0] forced to 2'b00 before loading PC; no ERR state; fetch_err tied 0.

## Structure
- NPC_* codes in shared ENCODE.v alongside ALU_* and EXT_*; state encodings local to ifu.
- One sub-module, npc: combinational next-PC calculator (PC, PCSrc, Zero, Imm32, Instr[25:0], RegRs → NPC).

## Test plan
- Reset, imem_ready=1, rvalid one cycle later, stall=0, PCSrc=PLUS4 → addresses 0x3000, 0x3004, 0x3008 each 3 cycles apart; instr_valid pulses one cycle each.
- PCSrc=BRANCH, Imm32=32'hFFFF_FFFE at PC 0x3010: Zero=1 → next 0x300C; Zero=0 → next 0x3014.
- PCSrc=JUMP, Instr=32'h0800_0C10 at PC 0x3020 → next 0x0000_3040; JR with RegRs=0x3100 → next 0x3100.
- imem_ready low 4 cycles, stall high 5 cycles in HOLD → imem_addr stable, Instr/PC/instr_valid unchanged, retire only after stall drops.
- rst asserted in WAIT → next cycle PC=0x3000, instr_valid=0, REQ reissued.
- With IFU_ALIGN_CHECK_EN, JR RegRs=0x3102 → fetch_err=1, no further imem_req; without it → fetch at 0x3100.

Source files
------------

// File: rtl/ifu_pkg.sv
// +----------------------------------------------------------------------------+
// | ifu_pkg: shared next-PC select codes and constants for the fetch unit.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifu_pkg;

   // PCSrc encodings shared with the control decoder (ALU_*/EXT_* live alongside)
   localparam logic [1:0] NPC_PLUS4  = 2'd0;
   localparam logic [1:0] NPC_BRANCH = 2'd1;
   localparam logic [1:0] NPC_JUMP   = 2'd2;
   localparam logic [1:0] NPC_JR     = 2'd3;

   localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] WORD_BYTES   = 32'd4;

endpackage

`default_nettype wire

// File: rtl/ifu_if.sv
// +----------------------------------------------------------------------------+
// | ifu_if: instruction-memory valid/ready request and read-data channel.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ifu_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, output addr, input ready, input rvalid, input rdata);
   modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/ifu_npc.sv
// +----------------------------------------------------------------------------+
// | ifu_npc: combinational next-PC calculator (PC+4, branch, jump, jr).         |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu_npc
   import ifu_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic        zero,
   input  logic [31:0] imm32,
   input  logic [25:0] instr_index,
   input  logic [31:0] reg_rs,
   output logic [31:0] npc
);

   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = pc + WORD_BYTES;

   always_comb begin
      npc = w_pc_plus4;
      case (pc_src)
         NPC_BRANCH: if (zero) npc = w_pc_plus4 + (imm32 << 2);
         NPC_JUMP:   npc = {w_pc_plus4[31:28], instr_index, 2'b00};
         NPC_JR:     npc = reg_rs;
         default:    npc = w_pc_plus4;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/ifu.sv
// +----------------------------------------------------------------------------+
// | ifu: instruction fetch unit - PC owner, imem handshake, next-PC update.     |
// | Optional macro IFU_ALIGN_CHECK_EN traps misaligned targets into ERR.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IFU_RESET_PC
)(
   input  logic        clk,
   input  logic        rst,
   ifu_if.master       imem,
   input  logic        stall,
   input  logic [1:0]  PCSrc,
   input  logic        Zero,
   input  logic [31:0] Imm32,
   input  logic [31:0] RegRs,
   output logic [31:0] Instr,
   output logic        instr_valid,
   output logic [31:0] PC,
   output logic [31:0] PC_plus4,
   output logic        fetch_err
);

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
`ifdef IFU_ALIGN_CHECK_EN
   localparam logic [1:0] S_ERR  = 2'd3;
`endif

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] w_npc;
   logic [31:0] w_pc_load;
   logic [1:0]  w_retire_state;

   ifu_npc u_npc (
      .pc          (r_pc),
      .pc_src      (PCSrc),
      .zero        (Zero),
      .imm32       (Imm32),
      .instr_index (r_instr[25:0]),
      .reg_rs      (RegRs),
      .npc         (w_npc)
   );

`ifdef IFU_ALIGN_CHECK_EN
   // Misaligned target is still loaded so the faulting address is visible on PC
   assign w_pc_load      = w_npc;
   assign w_retire_state = (w_npc[1:0] != 2'b00) ? S_ERR : S_REQ;
   assign fetch_err      = (r_state == S_ERR);
`else
   assign w_pc_load      = w_npc & ~32'd3;
   assign w_retire_state = S_REQ;
   assign fetch_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_REQ;
         r_pc    <= RESET_PC;
         r_instr <= '0;
      end else begin
         case (r_state)
            S_REQ:  if (imem.ready) r_state <= S_WAIT;
            S_WAIT: if (imem.rvalid) begin
                       r_instr <= imem.rdata;
                       r_state <= S_HOLD;
                    end
            S_HOLD: if (!stall) begin
                       r_pc    <= w_pc_load;
                       r_state <= w_retire_state;
                    end
            default: r_state <= r_state;
         endcase
      end
   end

   // Request and valid are masked during the reset cycle itself
   assign imem.req    = (r_state == S_REQ) && !rst;
   assign imem.addr   = r_pc;
   assign instr_valid = (r_state == S_HOLD) && !rst;
   assign Instr       = r_instr;
   assign PC          = r_pc;
   assign PC_plus4    = r_pc + WORD_BYTES;

endmodule

`default_nettype wire

// File: tb/tb_ifu.sv
// +----------------------------------------------------------------------------+
// | tb_ifu: vector table plus randomized fetch stream against a PC model.       |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ifu;

   typedef struct {
      logic [31:0] word;
      logic [1:0]  src;
      logic        zero;
      logic [31:0] imm;
      logic [31:0] rs;
      int          rdy_dly;
      int          rv_dly;
      int          stl;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [1:0]  PCSrc;
   logic        Zero;
   logic [31:0] Imm32;
   logic [31:0] RegRs;
   logic [31:0] Instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PC_plus4;
   logic        fetch_err;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] m_pc;
   vec_t        tbl [13];

   ifu_if bus ();

   ifu dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (bus),
      .stall       (stall),
      .PCSrc       (PCSrc),
      .Zero        (Zero),
      .Imm32       (Imm32),
      .RegRs       (RegRs),
      .Instr       (Instr),
      .instr_valid (instr_valid),
      .PC          (PC),
      .PC_plus4    (PC_plus4),
      .fetch_err   (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scramble_ctl();
      PCSrc = 2'($urandom_range(0, 3));
      Zero  = 1'($urandom_range(0, 1));
      Imm32 = $urandom;
      RegRs = $urandom;
   endtask

   // Runs one complete fetch/retire starting at a negedge in REQ.
   task automatic fetch(input vec_t v, output logic [31:0] nxt, output logic err);
      logic [31:0] p4;
      for (int k = 0; k < v.rdy_dly; k++) begin
         chk("req_wait_hi", 32'(bus.req), 32'd1);
         chk("addr_stable", bus.addr, m_pc);
         bus.ready  = 1'b0;
         bus.rvalid = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      chk("req_hi", 32'(bus.req), 32'd1);
      chk("req_addr", bus.addr, m_pc);
      bus.ready  = 1'b1;
      bus.rvalid = 1'b0;
      @(negedge clk);
      bus.ready = 1'b0;
      for (int k = 0; k < v.rv_dly; k++) begin
         chk("wait_req_lo", 32'(bus.req), 32'd0);
         chk("wait_iv_lo", 32'(instr_valid), 32'd0);
         @(negedge clk);
      end
      chk("wait_req_lo", 32'(bus.req), 32'd0);
      bus.rvalid = 1'b1;
      bus.rdata  = v.word;
      @(negedge clk);
      bus.rvalid = 1'b0;
      bus.rdata  = $urandom;
      for (int k = 0; k < v.stl; k++) begin
         chk("stall_iv", 32'(instr_valid), 32'd1);
         chk("stall_instr", Instr, v.word);
         chk("stall_pc", PC, m_pc);
         stall = 1'b1;
         scramble_ctl();
         @(negedge clk);
      end
      chk("hold_iv", 32'(instr_valid), 32'd1);
      chk("hold_instr", Instr, v.word);
      chk("hold_pc", PC, m_pc);
      chk("hold_pc4", PC_plus4, m_pc + 32'd4);
      stall = 1'b0;
      PCSrc = v.src;
      Zero  = v.zero;
      Imm32 = v.imm;
      RegRs = v.rs;
      p4 = m_pc + 32'd4;
      case (v.src)
         2'd0:    nxt = p4;
         2'd1:    nxt = v.zero ? p4 + v.imm * 32'd4 : p4;
         2'd2:    nxt = (p4 & 32'hF000_0000) | ((v.word & 32'h03FF_FFFF) * 32'd4);
         default: nxt = v.rs;
      endcase
`ifdef IFU_ALIGN_CHECK_EN
      err = (nxt % 4) != 0;
`else
      err = 1'b0;
      nxt = nxt - (nxt % 4);
`endif
      @(negedge clk);
      scramble_ctl();
      chk("retire_pc", PC, nxt);
      chk("retire_iv", 32'(instr_valid), 32'd0);
      chk("retire_err", 32'(fetch_err), 32'(err));
      chk("retire_req", 32'(bus.req), err ? 32'd0 : 32'd1);
      m_pc = nxt;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_pc = 32'h0000_3000;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] nxt;
      logic        err;
      vec_t        v;

      tbl[0]  = '{32'h2000_0001, 2'd0, 1'b1, 32'h0000_0010, 32'h0, 0, 0, 0, 32'h0000_3004};
      tbl[1]  = '{32'h2000_0002, 2'd0, 1'b0, 32'h0,         32'h0, 4, 0, 5, 32'h0000_3008};
      tbl[2]  = '{32'h2000_0003, 2'd0, 1'b0, 32'h0,         32'h0, 0, 2, 0, 32'h0000_300C};
      tbl[3]  = '{32'h2000_0004, 2'd0, 1'b0, 32'h0,         32'h0, 0, 0, 0, 32'h0000_3010};
      tbl[4]  = '{32'h1000_FFFE, 2'd1, 1'b1, 32'hFFFF_FFFE, 32'h0, 0, 0, 1, 32'h0000_300C};
      tbl[5]  = '{32'h2000_0005, 2'd0, 1'b0, 32'h0,         32'h0, 1, 1, 0, 32'h0000_3010};
      tbl[6]  = '{32'h1000_FFFE, 2'd1, 1'b0, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 32'h0000_3014};
      tbl[7]  = '{32'h03E0_0008, 2'd3, 1'b0, 32'h0, 32'h0000_3020, 0, 0, 0, 32'h0000_3020};
      tbl[8]  = '{32'h0800_0C10, 2'd2, 1'b1, 32'h0,         32'h0, 0, 0, 2, 32'h0000_3040};
      tbl[9]  = '{32'h03E0_0008, 2'd3, 1'b0, 32'h0, 32'h0000_3100, 0, 0, 0, 32'h0000_3100};
      tbl[10] = '{32'h03E0_0008, 2'd3, 1'b0, 32'h0, 32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFFC};
      tbl[11] = '{32'h2000_0006, 2'd0, 1'b0, 32'h0,         32'h0, 0, 0, 0, 32'h0000_0000};
      tbl[12] = '{32'h03E0_0008, 2'd3, 1'b0, 32'h0, 32'h0000_3000, 0, 0, 0, 32'h0000_3000};

      rst = 1'b1; stall = 1'b0; PCSrc = 2'd0; Zero = 1'b0; Imm32 = '0; RegRs = '0;
      bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_addr", bus.addr, 32'h0000_3000);
      chk("rst_pc", PC, 32'h0000_3000);
      chk("rst_pc4", PC_plus4, 32'h0000_3004);
      chk("rst_instr", Instr, 32'h0);
      chk("rst_iv", 32'(instr_valid), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      rst = 1'b0;
      m_pc = 32'h0000_3000;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         fetch(tbl[i], nxt, err);
         chk("tbl_next_pc", PC, tbl[i].exp);
      end

      // Reset while a read response is pending in WAIT
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      chk("pre_rst_wait", 32'(bus.req), 32'd0);
      rst = 1'b1;
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("wrst_req", 32'(bus.req), 32'd0);
      chk("wrst_pc", PC, 32'h0000_3000);
      chk("wrst_instr", Instr, 32'h0);
      chk("wrst_iv", 32'(instr_valid), 32'd0);
      rst = 1'b0;
      bus.rvalid = 1'b0;
      @(negedge clk);
      chk("wrst_reissue", 32'(bus.req), 32'd1);
      chk("wrst_addr", bus.addr, 32'h0000_3000);
      m_pc = 32'h0000_3000;

      // Misaligned jr target
      v = '{32'h03E0_0008, 2'd3, 1'b0, 32'h0, 32'h0000_3102, 0, 0, 0, 32'h0};
      fetch(v, nxt, err);
`ifdef IFU_ALIGN_CHECK_EN
      for (int k = 0; k < 3; k++) begin
         bus.ready = 1'b1;
         @(negedge clk);
         chk("err_sticky", 32'(fetch_err), 32'd1);
         chk("err_no_req", 32'(bus.req), 32'd0);
         chk("err_pc", PC, 32'h0000_3102);
      end
      bus.ready = 1'b0;
`else
      chk("align_fetch", bus.addr, 32'h0000_3100);
      chk("align_no_err", 32'(fetch_err), 32'd0);
`endif
      do_reset();

      for (int i = 0; i < 40; i++) begin
         v.word    = $urandom;
         v.src     = 2'($urandom_range(0, 3));
         v.zero    = 1'($urandom_range(0, 1));
         v.imm     = 32'($urandom_range(0, 63)) - 32'd32;
`ifdef IFU_ALIGN_CHECK_EN
         v.rs      = $urandom & 32'h0000_FFFC;
`else
         v.rs      = $urandom & 32'h0000_FFFF;
`endif
         v.rdy_dly = $urandom_range(0, 2);
         v.rv_dly  = $urandom_range(0, 2);
         v.stl     = $urandom_range(0, 2);
         v.exp     = '0;
         fetch(v, nxt, err);
         if (err) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
